// File: rtl/ssd_score_vga.sv
// Multi-digit seven-segment renderer: sequential double-dabble BCD conversion,
// frame-synchronous digit commit and a registered per-pixel lit bit.
// Optional macro SSD_BLINK_EN adds a blink input driven by a 64-frame counter.
module ssd_score_vga #(
   parameter int DIGITS  = 4,
   parameter int VAL_W   = 14,
   parameter int COORD_W = 11,
   parameter int SEG_T   = 10,
   parameter int SEG_L   = 30,
   parameter int GAP     = 10
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [VAL_W-1:0]   value,
   input  logic               value_valid,
   output logic               busy,
   input  logic               frame_start,
   input  logic               blank_lz,
   input  logic [COORD_W-1:0] s_x,
   input  logic [COORD_W-1:0] s_y,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
`ifdef SSD_BLINK_EN
   input  logic               blink,
`endif
   output logic               pix
);
   localparam int CW    = COORD_W + 2;
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(VAL_W + 1);
   localparam int PITCH = 2*SEG_T + SEG_L + GAP;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int k = 0; k < n; k++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0]      LIMIT = pow10(DIGITS);
   localparam logic [VAL_W-1:0] SAT   = VAL_W'(LIMIT - 64'd1);

   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int k = 0; k < DIGITS; k++)
         if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b0111111;
         4'd1:    seg7 = 7'b0000110;
         4'd2:    seg7 = 7'b1011011;
         4'd3:    seg7 = 7'b1001111;
         4'd4:    seg7 = 7'b1100110;
         4'd5:    seg7 = 7'b1101101;
         4'd6:    seg7 = 7'b1111101;
         4'd7:    seg7 = 7'b0000111;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1101111;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

   function automatic logic seg_hit(input int dx, input int dy, input int x0, input int y0,
                                    input int w, input int h);
      return (dx >= x0) && (dx < x0 + w) && (dy >= y0) && (dy < y0 + h);
   endfunction

   // Negative offsets (pixel left of / above the digit) never fall inside any segment.
   function automatic logic cell_lit(input logic [6:0] s, input logic signed [CW-1:0] dx,
                                     input logic signed [CW-1:0] dy);
      int ix, iy;
      ix = int'(dx);
      iy = int'(dy);
      return (s[0] && seg_hit(ix, iy, SEG_T,         0,                 SEG_L, SEG_T)) ||
             (s[1] && seg_hit(ix, iy, SEG_T + SEG_L, SEG_T,             SEG_T, SEG_L)) ||
             (s[2] && seg_hit(ix, iy, SEG_T + SEG_L, 2*SEG_T + SEG_L,   SEG_T, SEG_L)) ||
             (s[3] && seg_hit(ix, iy, SEG_T,         2*SEG_T + 2*SEG_L, SEG_L, SEG_T)) ||
             (s[4] && seg_hit(ix, iy, 0,             2*SEG_T + SEG_L,   SEG_T, SEG_L)) ||
             (s[5] && seg_hit(ix, iy, 0,             SEG_T,             SEG_T, SEG_L)) ||
             (s[6] && seg_hit(ix, iy, SEG_T,         SEG_T + SEG_L,     SEG_L, SEG_T));
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt;
   logic               accept, done, last_step;
   logic [VAL_W-1:0]   bin;
   logic [BCD_W-1:0]   bcd, dd_adj, pend, disp;
   logic               pend_v;
   logic               force_off;
   logic               lit_p0;

   assign last_step = (cnt == CNT_W'(VAL_W - 1));
   assign dd_adj    = add3(bcd);

   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      accept  = 1'b0;
      done    = 1'b0;
      case (state)
         IDLE: if (value_valid) begin
            accept  = 1'b1;
            state_n = CONV;
         end
         CONV: begin
            busy = 1'b1;
            if (last_step) state_n = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N)      cnt <= '0;
      else if (accept) cnt <= '0;
      else if (busy)   cnt <= cnt + 1'b1;
   end

   // Conversion datapath: saturating operand load, then one shift-and-add-3 step per cycle.
   always_ff @(posedge CLK) begin
      if (accept) begin
         bin <= ({{(64-VAL_W){1'b0}}, value} >= LIMIT) ? SAT : value;
         bcd <= '0;
      end else if (busy) begin
         bcd <= BCD_W'({dd_adj, bin[VAL_W-1]});
         bin <= {bin[VAL_W-2:0], 1'b0};
      end
   end

   // A commit uses pend_v from before this edge; a result finishing now stays pending.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pend   <= '0;
         pend_v <= 1'b0;
         disp   <= '0;
      end else begin
         if (frame_start && pend_v) begin
            disp   <= pend;
            pend_v <= 1'b0;
         end
         if (done) begin
            pend   <= bcd;
            pend_v <= 1'b1;
         end
      end
   end

`ifdef SSD_BLINK_EN
   logic [5:0] fcnt;

   always_ff @(posedge CLK) begin
      if (!RST_N)           fcnt <= '0;
      else if (frame_start) fcnt <= fcnt + 6'd1;
   end

   assign force_off = blink & fcnt[5];
`else
   assign force_off = 1'b0;
`endif

   // Stage p0: per-digit hit test with leading-zero mask from the displayed digits.
   always_comb begin
      logic                 lead, show;
      logic [3:0]           nib;
      logic signed [CW-1:0] dx, dy;
      lit_p0 = 1'b0;
      lead   = 1'b1;
      show   = 1'b1;
      nib    = '0;
      dx     = '0;
      dy     = CW'(y) - CW'(s_y);
      for (int i = 0; i < DIGITS; i++) begin
         nib  = disp[4*(DIGITS-1-i) +: 4];
         lead = lead & (nib == 4'd0);
         show = !(blank_lz && lead && (i != DIGITS - 1));
         dx   = CW'(x) - CW'(s_x) - CW'(i * PITCH);
         if (show && cell_lit(seg7(nib), dx, dy)) lit_p0 = 1'b1;
      end
   end

   // Stage p1: registered lit bit.
   always_ff @(posedge CLK) begin
      if (!RST_N) pix <= 1'b0;
      else        pix <= lit_p0 & ~force_off;
   end
endmodule

// File: tb/tb_ssd_score_vga.sv
// Self-checking bench for ssd_score_vga: directed sequence with random pixel sampling
// against an arithmetic (div/mod + rectangle table) display model.
module tb_ssd_score_vga;
   localparam int DIGITS = 4, VAL_W = 14, COORD_W = 11, T = 10, L = 30, GAP = 10;
   localparam int W = 2*T + L, H = 3*T + 2*L, P = W + GAP;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [VAL_W-1:0]   value = '0;
   logic               value_valid = 1'b0;
   logic               busy;
   logic               frame_start = 1'b0;
   logic               blank_lz = 1'b0;
   logic [COORD_W-1:0] s_x = '0, s_y = '0, x = '0, y = '0;
   logic               pix;
`ifdef SSD_BLINK_EN
   logic               blink = 1'b0;
`endif

   int n_chk = 0, n_err = 0;
   int disp_val = 0, pend_val = 0, frames = 0;
   bit pend_v = 1'b0;

   logic [6:0] codes [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
   int seg_x [7] = '{T, T+L, T+L, T, 0, 0, T};
   int seg_y [7] = '{0, T, 2*T+L, 2*T+2*L, 2*T+L, T, T+L};
   int seg_w [7] = '{L, T, T, L, T, T, L};
   int seg_h [7] = '{T, L, L, T, L, L, T};

   always #5 clk = ~clk;

   ssd_score_vga dut (
      .CLK(clk), .RST_N(rst_n), .value(value), .value_valid(value_valid), .busy(busy),
      .frame_start(frame_start), .blank_lz(blank_lz), .s_x(s_x), .s_y(s_y), .x(x), .y(y),
`ifdef SSD_BLINK_EN
      .blink(blink),
`endif
      .pix(pix)
   );

   function automatic bit ref_pix(int val, bit bl, int sx, int sy, int px, int py);
      int dx, dy, i, cx, p10, d;
      if (px < sx || py < sy) return 1'b0;
      dx = px - sx;
      dy = py - sy;
      i  = dx / P;
      cx = dx - i * P;
      if (i >= DIGITS || cx >= W || dy >= H) return 1'b0;
      p10 = 10 ** (DIGITS - 1 - i);
      if (bl && i < DIGITS - 1 && val < p10) return 1'b0;
      d = (val / p10) % 10;
      for (int s = 0; s < 7; s++)
         if (codes[d][s] && cx >= seg_x[s] && cx < seg_x[s] + seg_w[s] &&
             dy >= seg_y[s] && dy < seg_y[s] + seg_h[s]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic chk_pix(string tag, int px, int py);
      bit e;
      x = COORD_W'(px);
      y = COORD_W'(py);
      tick();
      e = ref_pix(disp_val, blank_lz, int'(s_x), int'(s_y), px, py);
`ifdef SSD_BLINK_EN
      if (blink && (frames % 64) >= 32) e = 1'b0;
`endif
      check(tag, {31'd0, pix}, {31'd0, e});
   endtask

   task automatic chk_const(string tag, int px, int py, bit e);
      x = COORD_W'(px);
      y = COORD_W'(py);
      tick();
      check(tag, {31'd0, pix}, {31'd0, e});
   endtask

   task automatic scan(string tag, int n);
      for (int k = 0; k < n; k++)
         chk_pix(tag, $urandom_range(int'(s_x) + 4*P + 5, 0), $urandom_range(int'(s_y) + H + 5, 0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      check("rst_pix", {31'd0, pix}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      disp_val = 0; pend_val = 0; pend_v = 1'b0; frames = 0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      frames++;
      if (pend_v) begin
         disp_val = pend_val;
         pend_v   = 1'b0;
      end
   endtask

   task automatic load(int v, bit poke, bit fs_done);
      int cnt;
      value       = VAL_W'(v);
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         if (poke && cnt == 3) begin
            value       = VAL_W'(5);
            value_valid = 1'b1;
         end
         tick();
         value_valid = 1'b0;
         cnt++;
      end
      check("busy_len", cnt, VAL_W);
      if (fs_done) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (fs_done) begin
         frames++;
         if (pend_v) begin
            disp_val = pend_val;
            pend_v   = 1'b0;
         end
      end
      pend_val = (v > 9999) ? 9999 : v;
      pend_v   = 1'b1;
      if (poke) begin
         tick();
         check("busy_ignored", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      do_reset();

      blank_lz = 1'b0;
      chk_const("zero_a_d0", 10, 0, 1'b1);
      chk_const("zero_g_d0", 15, 45, 1'b0);
      scan("zero_scan", 150);
      blank_lz = 1'b1;
      chk_const("zero_lz_d0", 10, 0, 1'b0);
      chk_const("zero_lz_d3", 190, 0, 1'b1);
      scan("zero_lz_scan", 150);

      blank_lz = 1'b0;
      load(1234, 1'b0, 1'b0);
      chk_const("pre_commit", 10, 0, 1'b1);
      frame();
      chk_const("v1234_d0_a", 10, 0, 1'b0);
      chk_const("v1234_d0_b", 40, 10, 1'b1);
      chk_const("v1234_d3_c", 225, 70, 1'b1);
      s_x = COORD_W'($urandom_range(300, 0));
      s_y = COORD_W'($urandom_range(300, 0));
      scan("v1234_scan", 200);
      s_x = '0; s_y = '0;

      load(7, 1'b0, 1'b0);
      frame();
      blank_lz = 1'b1;
      chk_const("v7_lz_d3", 190, 0, 1'b1);
      chk_const("v7_lz_d0", 10, 0, 1'b0);
      scan("v7_lz_scan", 150);
      blank_lz = 1'b0;
      chk_const("v7_nolz_d0", 10, 0, 1'b1);
      scan("v7_scan", 150);

      load(12000, 1'b1, 1'b0);
      frame();
      chk_const("sat_d0_g", 15, 45, 1'b1);
      scan("sat_scan", 150);

      load(4321, 1'b0, 1'b1);
      chk_const("fs_done_hold", 10, 0, 1'b1);
      frame();
      chk_const("fs_done_next", 10, 0, 1'b0);
      scan("v4321_scan", 100);

      load(42, 1'b0, 1'b0);
      load(5678, 1'b0, 1'b0);
      frame();
      blank_lz = 1'b1;
      scan("overwrite_scan", 150);
      blank_lz = 1'b0;

      do_reset();
      value       = VAL_W'(3333);
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      do_reset();
      tick();
      check("abort_busy", {31'd0, busy}, 32'd0);
      frame();
      chk_const("abort_no_commit", 15, 45, 1'b0);
      scan("abort_scan", 100);

`ifdef SSD_BLINK_EN
      load(8888, 1'b0, 1'b0);
      frame();
      blink = 1'b1;
      for (int f = 0; f < 128; f++) begin
         frame();
         chk_pix("blink", 10, 0);
      end
      blink = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
